object_batch_draw: RTL and testbench

OBJECT_BATCH_DRAW -- requirements
Module: object_batch_draw

---
 rtl/object_batch_draw.sv | 222 ++++++++++++++++++++++
 tb/tb_object_batch_draw.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/object_batch_draw.sv
// Batch sprite renderer: reads X/Y records for NUM_OBJ objects from memory and
// draws each as an SPR_W x SPR_H block through the datapath handshake.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 24
`endif
`ifndef OPCODE_MEMREAD
`define OPCODE_MEMREAD 4'd1
`endif
`ifndef OPCODE_DRAW
`define OPCODE_DRAW 4'd2
`endif
`ifndef X_COORD_WIDTH
`define X_COORD_WIDTH 8
`endif
`ifndef Y_COORD_WIDTH
`define Y_COORD_WIDTH 7
`endif
`ifndef COLOUR_WIDTH
`define COLOUR_WIDTH 3
`endif
`ifndef COLOUR_POISON
`define COLOUR_POISON 3'd5
`endif

module object_batch_draw #(
  parameter int NUM_OBJ = 4,
  parameter int SPR_W   = 2,
  parameter int SPR_H   = 2,
  parameter int X_BASE  = 0,
  parameter int Y_BASE  = 256,
  parameter logic [`COLOUR_WIDTH-1:0] COLOUR = `COLOUR_POISON,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          erase,
  output logic                          finished,
  output logic [`MEM_ADDR_WIDTH-1:0]    drawn_count,
  input  logic                          finished_dp,
  input  logic [`RESULT_WIDTH-1:0]      result_dp,
  output logic                          start_dp,
  output logic [`INSTRUCTION_WIDTH-1:0] instruction_dp
);
  localparam int XW   = `X_COORD_WIDTH;
  localparam int YW   = `Y_COORD_WIDTH;
  localparam int XW1  = XW + 1;
  localparam int YW1  = YW + 1;
  localparam int AW   = `MEM_ADDR_WIDTH;
  localparam int IW   = `INSTRUCTION_WIDTH;
  localparam int RW   = `RESULT_WIDTH;
  localparam int CW   = 4;
  localparam int IDXW = 8;

  localparam logic [XW:0]     X_LIM    = XW1'(X_MAX);
  localparam logic [YW:0]     Y_LIM    = YW1'(Y_MAX);
  localparam logic [CW-1:0]   DX_LAST  = CW'(SPR_W - 1);
  localparam logic [CW-1:0]   DY_LAST  = CW'(SPR_H - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_OBJ - 1);
  localparam logic [AW-1:0]   XB       = AW'(X_BASE);
  localparam logic [AW-1:0]   YB       = AW'(Y_BASE);

  typedef enum logic [2:0] {S_IDLE, S_RDX, S_RDY, S_PIX, S_NEXT} state_t;
  typedef enum logic [1:0] {PH_ISSUE, PH_HOLD, PH_WAIT} phase_t;

  state_t          state_q, state_d;
  phase_t          ph_q, ph_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic            erase_q, erase_d, any_q, any_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   instr_q, instr_d;

  logic [XW:0]     px;
  logic [YW:0]     py;
  logic [AW-1:0]   idx_ext;
  logic [`COLOUR_WIDTH-1:0] col;
  logic            clip, last_pix, active, issue_now, pix_done;
  logic [IW-1:0]   instr_cur;
  logic            unused_res;

  // Sums are one bit wider than the coordinates so off-screen never wraps.
  assign px       = {1'b0, x_q} + {{(XW1-CW){1'b0}}, dx_q};
  assign py       = {1'b0, y_q} + {{(YW1-CW){1'b0}}, dy_q};
  assign clip     = (px >= X_LIM) || (py >= Y_LIM);
  assign last_pix = (dx_q == DX_LAST) && (dy_q == DY_LAST);
  assign idx_ext  = {{(AW-IDXW){1'b0}}, idx_q};
  assign col      = erase_q ? '0 : COLOUR;
  assign unused_res = ^result_dp[RW-1:XW];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= PH_ISSUE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      erase_q <= 1'b0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      erase_q <= erase_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    erase_d  = erase_q;
    any_d    = any_q;
    cnt_d    = cnt_q;
    pix_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RDX;
        ph_d    = PH_ISSUE;
        erase_d = erase;
        idx_d   = '0;
        cnt_d   = '0;
      end
      S_RDX, S_RDY: begin
        case (ph_q)
          PH_ISSUE: ph_d = PH_HOLD;
          PH_HOLD:  ph_d = PH_WAIT;
          default: if (finished_dp) begin
            ph_d = PH_ISSUE;
            if (state_q == S_RDX) begin
              x_d     = result_dp[XW-1:0];
              state_d = (&result_dp[XW-1:0]) ? S_NEXT : S_RDY;
            end else begin
              y_d     = result_dp[YW-1:0];
              state_d = S_PIX;
              dx_d    = '0;
              dy_d    = '0;
              any_d   = 1'b0;
            end
          end
        endcase
      end
      S_PIX: begin
        case (ph_q)
          PH_ISSUE: if (clip) pix_done = 1'b1; else ph_d = PH_HOLD;
          PH_HOLD:  ph_d = PH_WAIT;
          default: if (finished_dp) begin
            pix_done = 1'b1;
            any_d    = 1'b1;
          end
        endcase
        if (pix_done) begin
          ph_d = PH_ISSUE;
          if (last_pix) begin
            state_d = S_NEXT;
            if (any_d) cnt_d = cnt_q + AW'(1);
          end else if (dx_q == DX_LAST) begin
            dx_d = '0;
            dy_d = dy_q + CW'(1);
          end else begin
            dx_d = dx_q + CW'(1);
          end
        end
      end
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = S_RDX;
          ph_d    = PH_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_cur = instr_q;
    case (state_q)
      S_RDX:   instr_cur = IW'({XB + idx_ext, `OPCODE_MEMREAD});
      S_RDY:   instr_cur = IW'({YB + idx_ext, `OPCODE_MEMREAD});
      S_PIX:   instr_cur = IW'({1'b1, col, py[YW-1:0], px[XW-1:0], `OPCODE_DRAW});
      default: instr_cur = instr_q;
    endcase
  end

  // Outputs: a clipped pixel neither pulses start_dp nor disturbs instruction_dp.
  always_comb begin
    active         = (state_q == S_RDX) || (state_q == S_RDY) || (state_q == S_PIX);
    issue_now      = active && (ph_q == PH_ISSUE) && !((state_q == S_PIX) && clip);
    start_dp       = issue_now || (active && (ph_q == PH_HOLD));
    instr_d        = issue_now ? instr_cur : instr_q;
    instruction_dp = instr_d;
    finished       = (state_q == S_IDLE);
    drawn_count    = cnt_q;
  end
endmodule

// File: tb/tb_object_batch_draw.sv
// Scoreboard bench for object_batch_draw: expected instructions are queued by
// the stimulus, and a datapath model checks and answers each request.
module tb_object_batch_draw;
  localparam int POISON = 5;
  localparam int BUDGET = 3000;

  logic        clock = 1'b0;
  logic        reset, start, erase, finished, finished_dp, start_dp;
  logic [15:0] drawn_count, result_dp;
  logic [23:0] instruction_dp;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  logic [15:0] mem [0:511];
  int txn_n = 0, draw_n = 0, idle_cnt = 0;
  int gap [0:63];
  int dly = 0;
  bit early_fin = 1'b0;

  object_batch_draw dut (
    .clock(clock), .reset(reset), .start(start), .erase(erase),
    .finished(finished), .drawn_count(drawn_count),
    .finished_dp(finished_dp), .result_dp(result_dp),
    .start_dp(start_dp), .instruction_dp(instruction_dp)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] mk_rd(input int a);
    logic [15:0] aa;
    aa = a[15:0];
    return {4'b0, aa, 4'd1};
  endfunction

  function automatic logic [23:0] mk_draw(input int c, input int y, input int x);
    logic [2:0] cc;
    logic [6:0] yy;
    logic [7:0] xx;
    cc = c[2:0];
    yy = y[6:0];
    xx = x[7:0];
    return {1'b0, 1'b1, cc, yy, xx, 4'd2};
  endfunction

  // Datapath model: issue seen at this negedge; hold and wait follow.
  task automatic serve();
    logic [23:0] ins, e;
    ins = instruction_dp;
    if (txn_n < 64) gap[txn_n] = idle_cnt;
    txn_n++;
    if (ins[3:0] == 4'd2) draw_n++;
    $display("txn %0d instr=%06h", txn_n, ins);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL txn_unexpected: got %06h want none", ins);
    end else begin
      e = exp_q.pop_front();
      if (ins !== e) begin
        bad++;
        $display("FAIL txn_instr: got %06h want %06h", ins, e);
      end
    end
    if (early_fin) begin
      finished_dp = 1'b1;
      result_dp   = 16'h00FF;
    end
    @(negedge clock);
    if (reset) return;
    check("hold", {7'b0, start_dp, instruction_dp}, {7'b0, 1'b1, ins});
    @(negedge clock);
    if (reset) return;
    finished_dp = 1'b0;
    check("wait_low", {31'b0, start_dp}, 32'd0);
    repeat (dly) begin
      @(negedge clock);
      if (reset) return;
    end
    finished_dp = 1'b1;
    result_dp   = (ins[3:0] == 4'd1) ? mem[ins[12:4]] : 16'h0000;
  endtask

  initial begin : monitor
    finished_dp = 1'b0;
    result_dp   = 16'h0000;
    forever begin
      @(negedge clock);
      finished_dp = 1'b0;
      if (!reset && start_dp) begin
        serve();
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
    end
  end

  task automatic load_default();
    for (int k = 0; k < 512; k++) mem[k] = 16'h0;
    for (int k = 0; k < 4; k++) begin
      mem[k]       = 16'(10 * (k + 1));
      mem[256 + k] = 16'(5 + k);
    end
  endtask

  task automatic push_draw(input int c, input int y, input int x);
    exp_q.push_back(mk_draw(c, y, x));
  endtask

  task automatic push_obj(input int k, input int x, input int y, input int c);
    exp_q.push_back(mk_rd(k));
    exp_q.push_back(mk_rd(256 + k));
    push_draw(c, y, x);
    push_draw(c, y, x + 1);
    push_draw(c, y + 1, x);
    push_draw(c, y + 1, x + 1);
  endtask

  task automatic push_default(input int c);
    for (int k = 0; k < 4; k++) push_obj(k, 10 * (k + 1), 5 + k, c);
  endtask

  task automatic run_batch(input bit er, input bit poke, input int exp_cnt, input int exp_txn);
    int n;
    txn_n  = 0;
    draw_n = 0;
    @(negedge clock);
    start = 1'b1;
    erase = er;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", {31'b0, finished}, 32'd0);
    n = 0;
    while (finished !== 1'b1 && n < BUDGET) begin
      @(negedge clock);
      n++;
      if (poke && n == 20) erase = ~erase;
      if (poke && n == 30) start = 1'b1;
      if (poke && n == 31) start = 1'b0;
    end
    if (n >= BUDGET) begin
      total++;
      bad++;
      $display("FAIL batch_timeout: got busy want finished");
    end
    check("drawn_count", {16'b0, drawn_count}, exp_cnt);
    check("txn_total", txn_n, exp_txn);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin : stimulus
    int n;
    reset = 1'b1;
    start = 1'b0;
    erase = 1'b0;
    load_default();
    #2;
    check("rst_finished", {31'b0, finished}, 32'd1);
    check("rst_start_dp", {31'b0, start_dp}, 32'd0);
    check("rst_instr", {8'b0, instruction_dp}, 32'd0);
    check("rst_count", {16'b0, drawn_count}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_no_req", {30'b0, finished, start_dp}, 32'd2);

    // Default batch: 8 reads, 16 draws, first draw at (10,5)
    push_default(POISON);
    run_batch(1'b0, 1'b0, 4, 24);
    check("draws_default", draw_n, 16);
    check("gap_between_draws", gap[3], 1'b0);
    check("gap_next_state", gap[6], 32'd1);
    check("instr_held_idle", {8'b0, instruction_dp}, {8'b0, mk_draw(POISON, 9, 41)});

    // Dead marker on object 1 (upper result bits discarded before the test)
    mem[1] = 16'h12FF;
    push_obj(0, 10, 5, POISON);
    exp_q.push_back(mk_rd(1));
    push_obj(2, 30, 7, POISON);
    push_obj(3, 40, 8, POISON);
    run_batch(1'b0, 1'b0, 3, 19);
    check("draws_dead", draw_n, 12);
    mem[1] = 16'd20;

    // Corner object: one visible pixel, three clipped ones each one cycle
    mem[0]   = 16'd159;
    mem[256] = 16'd119;
    exp_q.push_back(mk_rd(0));
    exp_q.push_back(mk_rd(256));
    push_draw(POISON, 119, 159);
    for (int k = 1; k < 4; k++) push_obj(k, 10 * (k + 1), 5 + k, POISON);
    run_batch(1'b0, 1'b0, 4, 21);
    check("draws_clip", draw_n, 13);
    check("gap_clip", gap[3], 32'd4);
    load_default();

    // Erase latched at start; later erase toggle and start pulse ignored
    push_default(0);
    run_batch(1'b1, 1'b1, 4, 24);
    erase = 1'b0;

    // Slow datapath, then slower with finished_dp asserted during issue/hold
    dly = 1;
    push_default(POISON);
    run_batch(1'b0, 1'b0, 4, 24);
    dly = 5;
    early_fin = 1'b1;
    push_default(POISON);
    run_batch(1'b0, 1'b0, 4, 24);
    dly = 0;
    early_fin = 1'b0;

    // Reset during the first draw of object 2
    push_default(POISON);
    txn_n = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (txn_n < 15 && n < BUDGET) begin
      @(posedge clock);
      n++;
    end
    check("reach_obj2_pix", txn_n, 32'd15);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_finished", {31'b0, finished}, 32'd1);
    check("mid_rst_start_dp", {31'b0, start_dp}, 32'd0);
    check("mid_rst_instr", {8'b0, instruction_dp}, 32'd0);
    check("mid_rst_count", {16'b0, drawn_count}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (start_dp) n++;
    end
    check("no_req_after_rst", n, 32'd0);
    push_default(POISON);
    run_batch(1'b0, 1'b0, 4, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
